// File: rtl/stopwatch_bcd.sv
// MM:SS.cc stopwatch kept as six BCD digits, with debounced start/stop and clear keys.
// Drives the digit bus of the six-digit seven-segment scanner.
`timescale 1ns/1ps
module stopwatch_bcd #(
   parameter int unsigned TICK_DIV = 500_000,
   parameter int unsigned DEB_CNT  = 1_000_000
) (
   input  logic        CLK_50M,
   input  logic        RST_N,
   input  logic        KEY_START_N,
   input  logic        KEY_CLR_N,
   output logic [23:0] DIGITS,
   output logic        DIG_UPD,
   output logic        RUNNING,
   output logic        OVF
);

   localparam int unsigned     PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned     DB_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEB_CNT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

   // bit 0 = start/stop key, bit 1 = clear key
   logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]      deb_q, deb_d, deb_dly_q, deb_dly_d, press_q, press_d;
   logic [DB_W-1:0] start_cnt_q, start_cnt_d, clr_cnt_q, clr_cnt_d;
   state_t          state_q, state_d;
   logic [PS_W-1:0] presc_q, presc_d;
   logic [23:0]     digits_q, digits_d, digits_inc;
   logic            dig_upd_q, dig_upd_d, running_q, running_d, ovf_q, ovf_d;
   logic [4:0]      cy;
   logic            wrap, tick, start_press, clr_press;

   // Counter advances only while the synchronized level disagrees with the
   // accepted level, so DEB_CNT consecutive disagreeing samples flip it.
   function automatic logic [DB_W:0] deb_step(input logic sync, input logic deb,
                                              input logic [DB_W-1:0] cnt);
      deb_step = {deb, {DB_W{1'b0}}};
      if (sync != deb) begin
         if (cnt == DB_MAX) deb_step = {sync, {DB_W{1'b0}}};
         else               deb_step = {deb, cnt + 1'b1};
      end
   endfunction

   function automatic logic [4:0] bcd_inc(input logic [3:0] dig, input logic [3:0] lim,
                                          input logic cin);
      bcd_inc = {1'b0, dig};
      if (cin) bcd_inc = (dig == lim) ? {1'b1, 4'd0} : {1'b0, dig + 4'd1};
   endfunction

   always_comb begin
      sync1_d   = {KEY_CLR_N, KEY_START_N};
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      {deb_d[0], start_cnt_d} = deb_step(sync2_q[0], deb_q[0], start_cnt_q);
      {deb_d[1], clr_cnt_d}   = deb_step(sync2_q[1], deb_q[1], clr_cnt_q);
      press_d   = deb_dly_q & ~deb_q;
   end

   assign start_press = press_q[0];
   assign clr_press   = press_q[1];

   always_comb begin
      {cy[0], digits_inc[3:0]}   = bcd_inc(digits_q[3:0],   4'd9, 1'b1);
      {cy[1], digits_inc[7:4]}   = bcd_inc(digits_q[7:4],   4'd9, cy[0]);
      {cy[2], digits_inc[11:8]}  = bcd_inc(digits_q[11:8],  4'd9, cy[1]);
      {cy[3], digits_inc[15:12]} = bcd_inc(digits_q[15:12], 4'd5, cy[2]);
      {cy[4], digits_inc[19:16]} = bcd_inc(digits_q[19:16], 4'd9, cy[3]);
      {wrap,  digits_inc[23:20]} = bcd_inc(digits_q[23:20], 4'd5, cy[4]);
   end

   always_comb begin
      tick     = (state_q == ST_RUN) && (presc_q == PS_MAX);
      state_d  = state_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      ovf_d    = 1'b0;
      if (clr_press) begin
         state_d  = ST_IDLE;
         presc_d  = '0;
         digits_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_d = '0;
               if (start_press) state_d = ST_RUN;
            end
            ST_RUN: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  digits_d = digits_inc;
                  ovf_d    = wrap;
               end
               if (start_press) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (start_press) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
      dig_upd_d = (digits_d != digits_q);
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         deb_q       <= '1;
         deb_dly_q   <= '1;
         press_q     <= '0;
         start_cnt_q <= '0;
         clr_cnt_q   <= '0;
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         digits_q    <= '0;
         dig_upd_q   <= 1'b0;
         running_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         deb_dly_q   <= deb_dly_d;
         press_q     <= press_d;
         start_cnt_q <= start_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         state_q     <= state_d;
         presc_q     <= presc_d;
         digits_q    <= digits_d;
         dig_upd_q   <= dig_upd_d;
         running_q   <= running_d;
         ovf_q       <= ovf_d;
      end
   end

   assign DIGITS  = digits_q;
   assign DIG_UPD = dig_upd_q;
   assign RUNNING = running_q;
   assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed scenarios plus random key activity, checked
// every cycle against a centisecond-count reference model.
`timescale 1ns/1ps
module tb_stopwatch_bcd;

   localparam int TB_TICK = 4;
   localparam int TB_DEB  = 3;

   logic        CLK_50M = 1'b0;
   logic        RST_N   = 1'b0;
   logic        KEY_START_N = 1'b1;
   logic        KEY_CLR_N   = 1'b1;
   logic [23:0] DIGITS;
   logic        DIG_UPD, RUNNING, OVF;

   int n_cmp = 0;
   int n_err = 0;

   stopwatch_bcd #(.TICK_DIV(TB_TICK), .DEB_CNT(TB_DEB)) dut (
      .CLK_50M    (CLK_50M),
      .RST_N      (RST_N),
      .KEY_START_N(KEY_START_N),
      .KEY_CLR_N  (KEY_CLR_N),
      .DIGITS     (DIGITS),
      .DIG_UPD    (DIG_UPD),
      .RUNNING    (RUNNING),
      .OVF        (OVF)
   );

   always #10 CLK_50M = ~CLK_50M;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: elapsed time as a centisecond count, keys as edge timelines.
   int m_e, m_state, m_cs, m_presc;
   int m_sy1[2], m_sy2[2], m_deb[2], m_run[2], m_fall[2];
   bit m_upd, m_ovf;

   function automatic logic [23:0] to_bcd(input int cs);
      int m, s, c;
      m = cs / 6000;
      s = (cs / 100) % 60;
      c = cs % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic model_reset();
      m_e = 0; m_state = 0; m_cs = 0; m_presc = 0; m_upd = 0; m_ovf = 0;
      for (int k = 0; k < 2; k++) begin
         m_sy1[k] = 1; m_sy2[k] = 1; m_deb[k] = 1; m_run[k] = 0; m_fall[k] = -100;
      end
   endtask

   task automatic model_step(input bit rs, input bit rc);
      int raw[2];
      bit act[2];
      bit tick;
      int lvl, old_cs;
      raw[0] = rs; raw[1] = rc;
      m_e++;
      for (int k = 0; k < 2; k++) act[k] = (m_e == m_fall[k] + 2);
      for (int k = 0; k < 2; k++) begin
         lvl = m_sy2[k];
         m_sy2[k] = m_sy1[k];
         m_sy1[k] = raw[k];
         if (lvl != m_deb[k]) begin
            m_run[k]++;
            if (m_run[k] == TB_DEB) begin
               m_deb[k] = lvl;
               m_run[k] = 0;
               if (lvl == 0) m_fall[k] = m_e;
            end
         end else m_run[k] = 0;
      end
      tick = (m_state == 1) && (m_presc == TB_TICK - 1);
      old_cs = m_cs;
      m_upd = 0; m_ovf = 0;
      if (act[1]) begin
         m_upd = (m_cs != 0); m_cs = 0; m_presc = 0; m_state = 0;
      end else begin
         if (m_state == 1) begin
            if (tick) begin
               m_cs = (m_cs + 1) % 360000; m_upd = 1; m_ovf = (old_cs == 359999); m_presc = 0;
            end else m_presc++;
         end else if (m_state == 0) m_presc = 0;
         if (act[0]) m_state = (m_state == 1) ? 2 : 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("digits",  32'(DIGITS),  32'(to_bcd(m_cs)));
      chk("dig_upd", 32'(DIG_UPD), 32'(m_upd));
      chk("running", 32'(RUNNING), 32'(m_state == 1));
      chk("ovf",     32'(OVF),     32'(m_ovf));
   endtask

   task automatic cyc(input bit s, input bit c);
      KEY_START_N = s;
      KEY_CLR_N   = c;
      @(posedge CLK_50M);
      if (RST_N) model_step(s, c);
      else model_reset();
      #1;
      compare_all();
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int n = 0;
      while (m_cs != target && n < budget) begin
         cyc(1, 1);
         n++;
      end
      chk(tag, 32'(DIGITS), 32'(to_bcd(target)));
   endtask

   initial begin
      bit seen;
      model_reset();

      // reset held with keys toggling
      repeat (8) cyc(1'($urandom % 2), 1'($urandom % 2));
      chk("rst_digits", 32'(DIGITS), 32'h0);
      KEY_START_N = 1; KEY_CLR_N = 1;
      RST_N = 1;
      repeat (5) cyc(1, 1);
      chk("post_rst_digits", 32'(DIGITS), 32'h0);
      chk("post_rst_running", 32'(RUNNING), 32'h0);

      // start press, ten ticks
      repeat (10) cyc(0, 1);
      run_until(10, 200, "t2_digits_10");
      chk("t2_running", 32'(RUNNING), 32'h1);

      // glitch rejected, then pause at a random prescaler phase, then resume
      repeat (2) cyc(0, 1);
      repeat (8) cyc(1, 1);
      chk("t3_glitch_running", 32'(RUNNING), 32'h1);
      repeat ($urandom_range(0, 3)) cyc(1, 1);
      repeat (6) cyc(0, 1);
      repeat (10) cyc(1, 1);
      chk("t3_paused", 32'(RUNNING), 32'h0);
      repeat (6) cyc(0, 1);
      repeat (12) cyc(1, 1);
      chk("t3_resumed", 32'(RUNNING), 32'h1);

      // preload near full scale and wrap
      force dut.digits_q = 24'h595990;
      m_cs = 359990;
      #1 release dut.digits_q;
      seen = 0;
      repeat (100) if (!seen) begin
         cyc(1, 1);
         if (m_ovf) begin
            seen = 1;
            chk("t4_ovf", 32'(OVF), 32'h1);
            chk("t4_upd", 32'(DIG_UPD), 32'h1);
            chk("t4_zero", 32'(DIGITS), 32'h0);
            chk("t4_running", 32'(RUNNING), 32'h1);
         end
      end
      if (!seen) chk("t4_wrap_seen", 32'(OVF), 32'h1);
      cyc(1, 1);
      chk("t4_ovf_single", 32'(OVF), 32'h0);

      // coincident clear and start presses
      run_until(123, 800, "t5_digits_123");
      repeat (6) cyc(0, 0);
      repeat (10) cyc(1, 1);
      chk("t5_running", 32'(RUNNING), 32'h0);
      chk("t5_digits", 32'(DIGITS), 32'h0);
      repeat (20) cyc(1, 1);
      chk("t5_still_zero", 32'(DIGITS), 32'h0);

      // asynchronous reset mid-run
      repeat (6) cyc(0, 1);
      run_until(1234, 5200, "t6_digits_1234");
      RST_N = 0;
      #2;
      chk("t6_async_digits", 32'(DIGITS), 32'h0);
      chk("t6_async_running", 32'(RUNNING), 32'h0);
      chk("t6_async_upd", 32'(DIG_UPD), 32'h0);
      chk("t6_async_ovf", 32'(OVF), 32'h0);
      model_reset();
      repeat (3) cyc(1, 1);
      RST_N = 1;
      repeat (30) cyc(1, 1);
      chk("t6_idle_running", 32'(RUNNING), 32'h0);
      chk("t6_idle_digits", 32'(DIGITS), 32'h0);

      // random key activity, including bounces shorter than the debounce window
      repeat (150) begin
         int len;
         bit s, c;
         len = $urandom_range(1, 14);
         s = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
         c = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
         repeat (len) cyc(s, c);
      end
      repeat (20) cyc(1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
